// File: rtl/dpd_pkg.sv
// Shared constants for the DPD adaptation sequencer: FSM state codes and the
// default settle/adapt/hold timing used by top-level integration.
package dpd_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t SETTLE = 3'd1;
  localparam state_t ADAPT  = 3'd2;
  localparam state_t HOLD   = 3'd3;
  localparam state_t STOP   = 3'd4;

  // Settle covers the dpd loop latency (DELAY=507) plus margin.
  localparam int DEF_SETTLE_CYCLES = 1024;
  localparam int DEF_ADAPT_CYCLES  = 4096;
  localparam int DEF_HOLD_CYCLES   = 65536;

endpackage

// File: rtl/dpd_adapt_ctrl.sv
// DPD coefficient-adaptation sequencer: IDLE -> SETTLE -> ADAPT -> HOLD -> SETTLE ...
// Optional DPD_ADAPT_ITER_LIMIT_EN stops in STOP after MAX_ITER windows.
module dpd_adapt_ctrl
  import dpd_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int ADAPT_CYCLES  = DEF_ADAPT_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int CNT_W         = 20,
  parameter int ITER_W        = 16,
  parameter int MAX_ITER      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              link_ok,
  input  logic              start,
  output logic              dpd_adapt,
  output logic              busy,
  output logic              iter_done,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              abort
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ADAPT_LAST  = CNT_W'(ADAPT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              complete;
  logic              abort_n;

`ifdef DPD_ADAPT_ITER_LIMIT_EN
  localparam logic [ITER_W-1:0] BUDGET_LAST = ITER_W'(MAX_ITER - 1);
  logic [ITER_W-1:0] budget;
  logic              budget_clr;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_n  = state;
    cnt_n    = cnt + 1'b1;
    complete = 1'b0;
    abort_n  = 1'b0;
`ifdef DPD_ADAPT_ITER_LIMIT_EN
    budget_clr = 1'b0;
`endif
    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (!link_ok) begin
      abort_n = (state == SETTLE) || (state == ADAPT);
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = SETTLE;
          cnt_n   = '0;
        end
        SETTLE: if (cnt == SETTLE_LAST) begin
          state_n = ADAPT;
          cnt_n   = '0;
        end
        ADAPT: if (cnt == ADAPT_LAST) begin
          complete = 1'b1;
          cnt_n    = '0;
`ifdef DPD_ADAPT_ITER_LIMIT_EN
          state_n  = (budget == BUDGET_LAST) ? STOP : HOLD;
`else
          state_n  = HOLD;
`endif
        end
        HOLD: if (start || cnt == HOLD_LAST) begin
          state_n = SETTLE;
          cnt_n   = '0;
        end
`ifdef DPD_ADAPT_ITER_LIMIT_EN
        STOP: begin
          cnt_n = '0;
          if (start) begin
            budget_clr = 1'b1;
            state_n    = SETTLE;
          end
        end
`endif
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next-state decode so they line up with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      dpd_adapt <= 1'b0;
      busy      <= 1'b0;
      iter_done <= 1'b0;
      iter_cnt  <= '0;
      abort     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state     <= state_n;
      cnt       <= cnt_n;
      dpd_adapt <= (state_n == ADAPT);
      busy      <= (state_n == SETTLE) || (state_n == ADAPT);
      iter_done <= (state_n == ADAPT) && (cnt_n == ADAPT_LAST);
      abort     <= abort_n;
      if (complete && (iter_cnt != '1))
        iter_cnt <= iter_cnt + 1'b1;
    end
  end

`ifdef DPD_ADAPT_ITER_LIMIT_EN
  // Budget of windows since the last reset or restart-from-STOP; survives IDLE.
  always_ff @(posedge clk) begin
    if (reset || budget_clr)
      budget <= '0;
    else if (complete)
      budget <= budget + 1'b1;
  end
`endif

endmodule
